input_buffer_mc: RTL and testbench

Parametrised successor of the 3-channel activation input buffer. It holds NUM_CHANNEL independent per-channel circular FIFOs and presents an aligned NUM_RDATA-wide window from every channel in one read. Each accepted read pops a runtime-selectable stride, so overlapping convolution windows reuse buffered data. It sits between the activation loader and the PE array, and adds channel-aligned reads, a flush, and overflow/underflow flags.

---
 rtl/input_buffer_mc.sv | 141 ++++++++++++++
 tb/tb_input_buffer_mc.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/input_buffer_mc.sv
// Multi-channel activation input buffer: NUM_CHANNEL circular FIFOs that are read
// together as channel-aligned NUM_RDATA-wide windows and popped by a runtime stride.
module input_buffer_mc #(
  parameter int DAT_WIDTH     = 8,
  parameter int NUM_CHANNEL   = 3,
  parameter int NUM_RDATA     = 3,
  parameter int FF_DEPTH      = 8,
  parameter int FF_ADDR_WIDTH = 3,
  parameter int STR_WIDTH     = 2
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_CHANNEL*DAT_WIDTH-1:0]              i_data,
  input  logic [NUM_CHANNEL-1:0]                        i_data_val,
  input  logic                                          i_data_req,
  input  logic [STR_WIDTH-1:0]                          i_stride,
  input  logic                                          i_flush,
  output logic [NUM_CHANNEL*NUM_RDATA*DAT_WIDTH-1:0]    o_data,
  output logic                                          o_data_val,
  output logic [NUM_CHANNEL*(FF_ADDR_WIDTH+1)-1:0]      o_data_counter,
  output logic                                          o_rd_ready,
  output logic                                          o_full,
  output logic                                          o_empty,
  output logic [NUM_CHANNEL-1:0]                        o_overflow,
  output logic                                          o_underflow
);

  localparam int CNT_W = FF_ADDR_WIDTH + 1;
  localparam int SW    = (STR_WIDTH > CNT_W) ? STR_WIDTH : CNT_W;
  localparam int WIN_W = NUM_RDATA * DAT_WIDTH;

  logic [DAT_WIDTH-1:0]           mem_q   [NUM_CHANNEL][FF_DEPTH];
  logic [FF_ADDR_WIDTH-1:0]       wrPtr_q [NUM_CHANNEL];
  logic [FF_ADDR_WIDTH-1:0]       wrPtr_d [NUM_CHANNEL];
  logic [FF_ADDR_WIDTH-1:0]       rdPtr_q [NUM_CHANNEL];
  logic [FF_ADDR_WIDTH-1:0]       rdPtr_d [NUM_CHANNEL];
  logic [CNT_W-1:0]               count_q [NUM_CHANNEL];
  logic [CNT_W-1:0]               count_d [NUM_CHANNEL];
  logic [NUM_CHANNEL*WIN_W-1:0]   data_q, data_d;
  logic                           dataVal_q, dataVal_d;
  logic                           underflow_q, underflow_d;
  logic [NUM_CHANNEL-1:0]         overflow_q, overflow_d;
  logic [NUM_CHANNEL-1:0]         wrAcc;
  logic                           rdAcc;
  logic [SW-1:0]                  strideWide;
  logic [CNT_W-1:0]               strideEff;

  always_comb begin
    o_rd_ready     = 1'b1;
    o_full         = 1'b0;
    o_empty        = 1'b1;
    o_data_counter = '0;
    for (int c = 0; c < NUM_CHANNEL; c++) begin
      if (count_q[c] < CNT_W'(NUM_RDATA)) o_rd_ready = 1'b0;
      if (count_q[c] == CNT_W'(FF_DEPTH)) o_full = 1'b1;
      if (count_q[c] != '0)               o_empty = 1'b0;
      o_data_counter[c*CNT_W +: CNT_W] = count_q[c];
    end
  end

  // A zero stride still advances by one; strides beyond the window saturate.
  always_comb begin
    strideWide = SW'(i_stride);
    if (strideWide == '0)
      strideEff = CNT_W'(1);
    else if (strideWide > SW'(NUM_RDATA))
      strideEff = CNT_W'(NUM_RDATA);
    else
      strideEff = CNT_W'(strideWide);
  end

  assign rdAcc = i_data_req && o_rd_ready && !i_flush;

  always_comb begin
    data_d      = data_q;
    dataVal_d   = rdAcc;
    underflow_d = i_data_req && !o_rd_ready && !i_flush;
    overflow_d  = '0;
    wrAcc       = '0;
    for (int c = 0; c < NUM_CHANNEL; c++) begin
      wrPtr_d[c] = wrPtr_q[c];
      rdPtr_d[c] = rdPtr_q[c];
      count_d[c] = count_q[c];
      // A full channel can still take a write when the same cycle's read frees space.
      wrAcc[c]      = i_data_val[c] && !i_flush &&
                      ((count_q[c] != CNT_W'(FF_DEPTH)) || rdAcc);
      overflow_d[c] = i_data_val[c] && !i_flush && !wrAcc[c];
      if (i_flush) begin
        wrPtr_d[c] = '0;
        rdPtr_d[c] = '0;
        count_d[c] = '0;
      end else begin
        if (rdAcc) begin
          for (int k = 0; k < NUM_RDATA; k++)
            data_d[c*WIN_W + k*DAT_WIDTH +: DAT_WIDTH] =
              mem_q[c][rdPtr_q[c] + FF_ADDR_WIDTH'(k)];
          rdPtr_d[c] = rdPtr_q[c] + strideEff[FF_ADDR_WIDTH-1:0];
        end
        if (wrAcc[c]) wrPtr_d[c] = wrPtr_q[c] + FF_ADDR_WIDTH'(1);
        count_d[c] = count_q[c] + CNT_W'(wrAcc[c]) - (rdAcc ? strideEff : '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CHANNEL; c++) begin
        wrPtr_q[c] <= '0;
        rdPtr_q[c] <= '0;
        count_q[c] <= '0;
      end
      data_q      <= '0;
      dataVal_q   <= 1'b0;
      underflow_q <= 1'b0;
      overflow_q  <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNEL; c++) begin
        wrPtr_q[c] <= wrPtr_d[c];
        rdPtr_q[c] <= rdPtr_d[c];
        count_q[c] <= count_d[c];
      end
      data_q      <= data_d;
      dataVal_q   <= dataVal_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage needs no reset: the pointers and counts alone define what is valid.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CHANNEL; c++)
      if (!rst && wrAcc[c])
        mem_q[c][wrPtr_q[c]] <= i_data[c*DAT_WIDTH +: DAT_WIDTH];
  end

  assign o_data      = data_q;
  assign o_data_val  = dataVal_q;
  assign o_underflow = underflow_q;
  assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_input_buffer_mc.sv
// Randomised and directed bench for input_buffer_mc, checked every cycle against a
// shift-array model of each channel's queue.
module tb_input_buffer_mc;

  localparam int DW = 8;
  localparam int NC = 3;
  localparam int NR = 3;
  localparam int DEPTH = 8;
  localparam int AW = 3;
  localparam int SW = 2;
  localparam int CW = AW + 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NC*DW-1:0]       iData;
  logic [NC-1:0]          iDataVal;
  logic                   iDataReq;
  logic [SW-1:0]          iStride;
  logic                   iFlush;
  logic [NC*NR*DW-1:0]    oData;
  logic                   oDataVal;
  logic [NC*CW-1:0]       oDataCounter;
  logic                   oRdReady, oFull, oEmpty, oUnderflow;
  logic [NC-1:0]          oOverflow;

  int vectors = 0;
  int miscompares = 0;

  // Model: each channel is an array whose element 0 is always the oldest entry.
  logic [DW-1:0]          mq [NC][DEPTH];
  int                     mcnt [NC];
  logic [NC*NR*DW-1:0]    expData;
  logic                   expVal, expUnf;
  logic [NC-1:0]          expOvf;

  input_buffer_mc #(
    .DAT_WIDTH(DW), .NUM_CHANNEL(NC), .NUM_RDATA(NR),
    .FF_DEPTH(DEPTH), .FF_ADDR_WIDTH(AW), .STR_WIDTH(SW)
  ) dut (
    .clk(clk), .rst(rst),
    .i_data(iData), .i_data_val(iDataVal), .i_data_req(iDataReq),
    .i_stride(iStride), .i_flush(iFlush),
    .o_data(oData), .o_data_val(oDataVal), .o_data_counter(oDataCounter),
    .o_rd_ready(oRdReady), .o_full(oFull), .o_empty(oEmpty),
    .o_overflow(oOverflow), .o_underflow(oUnderflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [NC*DW-1:0] d, input logic [NC-1:0] v,
                               input logic rq, input logic [SW-1:0] st, input logic fl);
    logic ready, rd, allReady, anyFull, allEmpty;
    logic [NC-1:0] wr;
    int s;
    rst = r; iData = d; iDataVal = v; iDataReq = rq; iStride = st; iFlush = fl;
    if (r) begin
      for (int c = 0; c < NC; c++) mcnt[c] = 0;
      expData = '0; expVal = 1'b0; expOvf = '0; expUnf = 1'b0;
    end else if (fl) begin
      for (int c = 0; c < NC; c++) mcnt[c] = 0;
      expVal = 1'b0; expOvf = '0; expUnf = 1'b0;
    end else begin
      ready = 1'b1;
      for (int c = 0; c < NC; c++) if (mcnt[c] < NR) ready = 1'b0;
      rd = rq && ready;
      s = (st == 0) ? 1 : ((int'(st) > NR) ? NR : int'(st));
      expVal = rd;
      expUnf = rq && !ready;
      for (int c = 0; c < NC; c++) begin
        wr[c] = v[c] && (mcnt[c] < DEPTH || rd);
        expOvf[c] = v[c] && !wr[c];
      end
      if (rd) begin
        for (int c = 0; c < NC; c++) begin
          for (int k = 0; k < NR; k++) expData[(c*NR+k)*DW +: DW] = mq[c][k];
          for (int j = 0; j < mcnt[c] - s; j++) mq[c][j] = mq[c][j+s];
          mcnt[c] -= s;
        end
      end
      for (int c = 0; c < NC; c++)
        if (wr[c]) begin
          mq[c][mcnt[c]] = d[c*DW +: DW];
          mcnt[c]++;
        end
    end
    @(posedge clk);
    #1;
    allReady = 1'b1; anyFull = 1'b0; allEmpty = 1'b1;
    for (int c = 0; c < NC; c++) begin
      if (mcnt[c] < NR) allReady = 1'b0;
      if (mcnt[c] == DEPTH) anyFull = 1'b1;
      if (mcnt[c] != 0) allEmpty = 1'b0;
      checkOutput($sformatf("count%0d", c), 128'(oDataCounter[c*CW +: CW]), 128'(mcnt[c]));
    end
    checkOutput("dataVal", 128'(oDataVal), 128'(expVal));
    checkOutput("data", 128'(oData), 128'(expData));
    checkOutput("underflow", 128'(oUnderflow), 128'(expUnf));
    checkOutput("overflow", 128'(oOverflow), 128'(expOvf));
    checkOutput("rdReady", 128'(oRdReady), 128'(allReady));
    checkOutput("full", 128'(oFull), 128'(anyFull));
    checkOutput("empty", 128'(oEmpty), 128'(allEmpty));
  endtask

  function automatic logic [NC*DW-1:0] rowData(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {8'h30 + b, 8'h20 + b, 8'h10 + b};
  endfunction

  initial begin
    int unsigned wrBias;
    logic [NC-1:0] v;
    applyStimulus(1, '0, '0, 0, 0, 0);
    applyStimulus(1, '0, '0, 0, 0, 0);
    for (int i = 0; i < 2; i++) applyStimulus(0, '0, '0, 0, 0, 0);
    checkOutput("idleEmpty", 128'(oEmpty), 128'(1));
    checkOutput("idleReady", 128'(oRdReady), 128'(0));

    // Stride-1 reads reuse overlapping data.
    for (int i = 0; i < 5; i++) applyStimulus(0, rowData(i), 3'b111, 0, 0, 0);
    applyStimulus(0, '0, '0, 1, 1, 0);
    checkOutput("win1", 128'(oData[23:0]), 128'(24'h121110));
    checkOutput("win1ch2", 128'(oData[71:48]), 128'(24'h323130));
    checkOutput("cnt4", 128'(oDataCounter[3:0]), 128'(4));
    applyStimulus(0, '0, '0, 1, 1, 0);
    checkOutput("win2", 128'(oData[23:0]), 128'(24'h131211));
    checkOutput("cnt3", 128'(oDataCounter[3:0]), 128'(3));

    // Stride 3 drains below the window, then a read is rejected.
    applyStimulus(0, '0, '0, 0, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, rowData(i), 3'b111, 0, 0, 0);
    applyStimulus(0, '0, '0, 1, 3, 0);
    checkOutput("winS3", 128'(oData[23:0]), 128'(24'h121110));
    checkOutput("cnt2", 128'(oDataCounter[3:0]), 128'(2));
    checkOutput("notReady", 128'(oRdReady), 128'(0));
    applyStimulus(0, '0, '0, 1, 1, 0);
    checkOutput("unfPulse", 128'(oUnderflow), 128'(1));
    checkOutput("unfNoVal", 128'(oDataVal), 128'(0));

    // Overflow on a full channel, then a write paired with a read is accepted.
    applyStimulus(0, '0, '0, 0, 0, 1);
    for (int i = 0; i < 8; i++) applyStimulus(0, rowData(i), (i < 7) ? 3'b111 : 3'b001, 0, 0, 0);
    applyStimulus(0, 24'h0000AA, 3'b001, 0, 0, 0);
    checkOutput("ovf0", 128'(oOverflow), 128'(3'b001));
    checkOutput("ovfCnt", 128'(oDataCounter[3:0]), 128'(8));
    checkOutput("ovfFull", 128'(oFull), 128'(1));
    applyStimulus(0, 24'h0000BB, 3'b001, 1, 1, 0);
    checkOutput("rwCnt", 128'(oDataCounter[3:0]), 128'(8));
    checkOutput("rwNoOvf", 128'(oOverflow), 128'(0));

    // Continuous write/read across the pointer wrap.
    applyStimulus(0, '0, '0, 0, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, rowData(i), 3'b111, 0, 0, 0);
    for (int i = 3; i < 23; i++) applyStimulus(0, rowData(i), 3'b111, 1, 1, 0);

    // Flush with a simultaneous read and write.
    applyStimulus(0, '0, '0, 0, 0, 1);
    for (int i = 0; i < 6; i++) applyStimulus(0, rowData(i), 3'b111, 0, 0, 0);
    applyStimulus(0, rowData(9), 3'b111, 1, 1, 1);
    checkOutput("flushCnt", 128'(oDataCounter), 128'(0));
    checkOutput("flushNoVal", 128'(oDataVal), 128'(0));

    // Reset in the middle of traffic.
    for (int i = 0; i < 4; i++) applyStimulus(0, rowData(i), 3'b111, 1, 1, 0);
    applyStimulus(1, rowData(5), 3'b111, 1, 1, 0);
    checkOutput("rstData", 128'(oData), 128'(0));
    checkOutput("rstEmpty", 128'(oEmpty), 128'(1));

    wrBias = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) wrBias = $urandom_range(20, 95);
      for (int c = 0; c < NC; c++) v[c] = ($urandom_range(0, 99) < wrBias);
      applyStimulus(($urandom_range(0, 399) == 0), 24'($urandom), v,
                    ($urandom_range(0, 99) < 60), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 79) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
